// File: rtl/load_store_unit.sv
// RV32I load/store stage: one outstanding bus transfer, store lane alignment, load extraction.
// Optional REQ-state timeout abort is compiled in by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d, bus_err_q, bus_err_d;
  logic        req_bad, in_req, to_hit;
  logic [31:0] ld_sh, ld_val;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;

  // Counter is held at zero outside REQ, so REQ entry always starts from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != REQ)  cnt_d = 8'd0;
    else if (!mem_ready) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign to_hit = (cnt_q == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    case (req_funct3)
      3'b000:         req_bad = 1'b0;
      3'b001:         req_bad = addr[0];
      3'b010:         req_bad = |addr[1:0];
      3'b100, 3'b101: req_bad = req_we | (req_funct3[0] & addr[0]);
      default:        req_bad = 1'b1;
    endcase
  end

  assign ld_sh = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_val = {24'b0, ld_sh[7:0]};
      3'b101:  ld_val = {16'b0, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

  assign in_req = (state_q == REQ);

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = 32'b0;
    if (in_req) begin
      case (f3_q[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << {addr_q[1], 1'b0};
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

  assign mem_req  = in_req;
  assign mem_we   = in_req & we_q;
  assign mem_addr = in_req ? {addr_q[31:2], 2'b00} : 32'b0;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign rdata    = rdata_q;
  assign fault    = fault_q;
  assign bus_err  = bus_err_q;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = addr;
        wdata_d = wdata;
        if (req_bad) begin
          state_d   = DONE;
          rdata_d   = 32'b0;
          fault_d   = 1'b1;
          bus_err_d = 1'b0;
        end else begin
          state_d = REQ;
        end
      end
      // A ready arriving on the timeout cycle still completes normally.
      REQ: if (mem_ready) begin
        state_d   = DONE;
        rdata_d   = we_q ? 32'b0 : ld_val;
        fault_d   = 1'b0;
        bus_err_d = 1'b0;
      end else if (to_hit) begin
        state_d   = DONE;
        rdata_d   = 32'b0;
        fault_d   = 1'b0;
        bus_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b0;
      addr_q    <= 32'b0;
      wdata_q   <= 32'b0;
      rdata_q   <= 32'b0;
      fault_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
      bus_err_q <= bus_err_d;
    end
  end
endmodule
